// File: rtl/alu_serial_exec.sv
// Chunk-serial ALU: add/sub/and/or/slt, CHUNK bits per cycle, LSB first.
// Optional ovf output when ALU_SERIAL_OVF_FLAG_EN is defined.
module alu_serial_exec #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_SERIAL_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             err
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
`ifdef ALU_SERIAL_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] a_c, b_c, b_x, r_c;
  logic [CHUNK:0]   sum_c;
  logic [WIDTH-1:0] res_new;
  logic             is_sub, cin, last, legal_in;
  logic             a_msb, b_msb, s_msb, ovf_c, lt;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign err       = err_q;
`ifdef ALU_SERIAL_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

  assign legal_in = (alu_ctrl != 3'b100) &&
                    (alu_ctrl[2:1] != 2'b11);

  // Datapath for the chunk selected by the counter.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
    is_sub = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
    b_x    = is_sub ? ~b_c : b_c;
    cin    = (cnt_q == '0) ? is_sub : carry_q;
    sum_c  = {1'b0, a_c} + {1'b0, b_x}
           + {{CHUNK{1'b0}}, cin};
    unique case (1'b1)
      (ctrl_q == OP_AND): r_c = a_c & b_c;
      (ctrl_q == OP_OR):  r_c = a_c | b_c;
      default:            r_c = sum_c[CHUNK-1:0];
    endcase
    res_new = res_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) res_new[i*CHUNK +: CHUNK] = r_c;
    end
    last  = (cnt_q == CW'(N-1));
    a_msb = a_q[WIDTH-1];
    b_msb = b_q[WIDTH-1];
    s_msb = sum_c[CHUNK-1];
    ovf_c = is_sub ? ((a_msb != b_msb) && (s_msb != a_msb))
                   : ((a_msb == b_msb) && (s_msb != a_msb));
    lt    = s_msb ^ ovf_c;
    if ((ctrl_q == OP_SLT) && last)
      res_new = {{(WIDTH-1){1'b0}}, lt};
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef ALU_SERIAL_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ctrl_d  = alu_ctrl;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = '0;
          carry_d = 1'b0;
          res_d   = '0;
          err_d   = !legal_in;
          zero_d  = !legal_in;
`ifdef ALU_SERIAL_OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
          state_d = legal_in ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        res_d   = res_new;
        carry_d = sum_c[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          zero_d  = (res_new == '0);
`ifdef ALU_SERIAL_OVF_FLAG_EN
          ovf_d   = (ctrl_q[2:1] == 2'b00) && ovf_c;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
`ifdef ALU_SERIAL_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec (WIDTH=32, CHUNK=8).
// Checks ovf too when ALU_SERIAL_OVF_FLAG_EN is defined.
module tb_alu_serial_exec;

  localparam int W = 32;
  localparam int C = 8;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_ctrl = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         err;
`ifdef ALU_SERIAL_OVF_FLAG_EN
  logic         ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  alu_serial_exec #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_ctrl(alu_ctrl),
    .src_a(src_a),
    .src_b(src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
`ifdef ALU_SERIAL_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op definitions.
  function automatic void model(input logic [2:0] c,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] r,
                                output logic e,
                                output logic o);
    r = '0;
    e = 1'b0;
    o = 1'b0;
    case (c)
      3'b000: begin
        r = a + b;
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b001: begin
        r = a - b;
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] c,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic ee, eo;
    int lat;
    model(c, a, b, er, ee, eo);
    @(negedge clk);
    chk("in_ready_idle", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    alu_ctrl  = c;
    src_a     = a;
    src_b     = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      alu_ctrl = 3'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", W'(lat), ee ? W'(0) : W'(NCH));
    chk("result", result, er);
    chk("zero", W'(zero), W'(er == '0));
    chk("err", W'(err), W'(ee));
`ifdef ALU_SERIAL_OVF_FLAG_EN
    chk("ovf", W'(ovf), W'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_ready", W'(in_ready), W'(0));
      chk("hold_result", result, er);
      chk("hold_err", W'(err), W'(ee));
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("post_valid", W'(out_valid), W'(0));
    chk("post_ready", W'(in_ready), W'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] rc;
    logic [W-1:0] ra, rb;
    #2;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'd5, 32'd7, 0);
    run_op(3'b000, 32'h0000_00FF, 32'd1, 0);
    run_op(3'b001, 32'd3, 32'd3, 0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    run_op(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(3'b100, 32'd9, 32'd4, 5);
    run_op(3'b110, 32'd1, 32'd1, 0);
    run_op(3'b111, 32'd2, 32'd2, 2);
    run_op(3'b000, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(3'b001, 32'h8000_0000, 32'd1, 0);
    run_op(3'b010, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 0);

    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 3'b000;
    src_a    = 32'h1234_5678;
    src_b    = 32'h1111_1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_ready", W'(in_ready), W'(1));
    chk("midrst_result", result, '0);
    chk("midrst_err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd1, 32'd1, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: rc = 3'b000;
        1: rc = 3'b001;
        2: rc = 3'b010;
        3: rc = 3'b011;
        4, 5: rc = 3'b101;
        default: rc = 3'($urandom);
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      run_op(rc, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
